// File: rtl/systolic_input_skew.sv
// West-edge feeder for the PE array: accepts ROWS-wide activation vectors and
// emits them as a diagonal wavefront (row r delayed r extra cycles), with tile tracking.

module systolic_input_skew_row #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  xfer,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  switch_in,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_switch
);
  logic [DEPTH-1:0][DATA_WIDTH-1:0] d_pipe;
  logic [DEPTH-1:0]                 v_pipe;
  logic [DEPTH-1:0]                 s_pipe;

  // Stage 0 loads every cycle; a non-transfer cycle becomes an all-zero bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_pipe <= '0;
      v_pipe <= '0;
      s_pipe <= '0;
    end else begin
      d_pipe[0] <= xfer ? data : '0;
      v_pipe[0] <= xfer;
      s_pipe[0] <= xfer & switch_in;
      for (int i = 1; i < DEPTH; i++) begin
        d_pipe[i] <= d_pipe[i-1];
        v_pipe[i] <= v_pipe[i-1];
        s_pipe[i] <= s_pipe[i-1];
      end
    end
  end

  assign out_data   = d_pipe[DEPTH-1];
  assign out_valid  = v_pipe[DEPTH-1];
  assign out_switch = s_pipe[DEPTH-1];
endmodule

module systolic_input_skew #(
  parameter int ROWS       = 4,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] in_data,
  input  logic                       in_switch,
  input  logic                       in_last,
  output logic [ROWS*DATA_WIDTH-1:0] row_input_out,
  output logic [ROWS-1:0]            row_valid_out,
  output logic [ROWS-1:0]            row_switch_out,
  output logic [CNT_WIDTH-1:0]       vec_count,
  output logic                       tile_done
);
  localparam int DW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          clr_cnt;
  logic          xfer;
  logic [ROWS-1:0] last_pipe;

  assign in_ready = (state_q != DRAIN);
  assign xfer     = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    clr_cnt = 1'b0;
    case (state_q)
      IDLE, STREAM: begin
        if (xfer) begin
          if (!in_last) begin
            state_d = STREAM;
          end else if (ROWS == 1) begin
            state_d = IDLE;
          end else begin
            state_d = DRAIN;
            drain_d = DW'(ROWS - 1);
          end
        end
      end
      DRAIN: begin
        // Leaving on the edge where the counter would hit zero gives ROWS-1 stalled cycles.
        if (drain_q <= DW'(1)) begin
          state_d = IDLE;
          drain_d = '0;
          clr_cnt = 1'b1;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      drain_q   <= '0;
      vec_count <= '0;
      last_pipe <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      // An accept in IDLE starts a new tile; matters only for ROWS=1 where no drain clears the count.
      if (clr_cnt)
        vec_count <= '0;
      else if (xfer && state_q == IDLE)
        vec_count <= CNT_WIDTH'(1);
      else if (xfer && vec_count != {CNT_WIDTH{1'b1}})
        vec_count <= vec_count + CNT_WIDTH'(1);
      last_pipe[0] <= xfer & in_last;
      for (int i = 1; i < ROWS; i++)
        last_pipe[i] <= last_pipe[i-1];
    end
  end

  assign tile_done = last_pipe[ROWS-1];

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    systolic_input_skew_row #(
      .DEPTH      (r + 1),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_row (
      .clk        (clk),
      .rst        (rst),
      .xfer       (xfer),
      .data       (in_data[r*DATA_WIDTH +: DATA_WIDTH]),
      .switch_in  (in_switch),
      .out_data   (row_input_out[r*DATA_WIDTH +: DATA_WIDTH]),
      .out_valid  (row_valid_out[r]),
      .out_switch (row_switch_out[r])
    );
  end
endmodule

// File: tb/tb_systolic_input_skew.sv
// Directed bench for systolic_input_skew (ROWS=4): skew timing, tile drain, bubbles, reset.

module tb_systolic_input_skew;
  localparam int ROWS = 4;
  localparam int DW   = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [ROWS*DW-1:0]   in_data = '0;
  logic                 in_switch = 1'b0;
  logic                 in_last = 1'b0;
  logic [ROWS*DW-1:0]   row_input_out;
  logic [ROWS-1:0]      row_valid_out;
  logic [ROWS-1:0]      row_switch_out;
  logic [15:0]          vec_count;
  logic                 tile_done;

  int checks   = 0;
  int failures = 0;

  // Expected-wavefront history: slot r holds what was accepted r edges ago.
  logic [ROWS*DW-1:0] hd [ROWS];
  logic               hv [ROWS];
  logic               hs [ROWS];

  systolic_input_skew #(.ROWS(ROWS), .DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_switch      (in_switch),
    .in_last        (in_last),
    .row_input_out  (row_input_out),
    .row_valid_out  (row_valid_out),
    .row_switch_out (row_switch_out),
    .vec_count      (vec_count),
    .tile_done      (tile_done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pack(input logic [15:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rows(input string tag);
    logic [ROWS*DW-1:0] ed;
    logic [ROWS-1:0]    ev, es;
    for (int r = 0; r < ROWS; r++) begin
      ed[r*DW +: DW] = hd[r][r*DW +: DW];
      ev[r] = hv[r];
      es[r] = hs[r];
    end
    chk({tag, ".data"},   row_input_out,  ed);
    chk({tag, ".valid"},  row_valid_out,  ev);
    chk({tag, ".switch"}, row_switch_out, es);
  endtask

  // One clock: drive inputs, take the edge, update the expected wavefront, check rows.
  task automatic step(input string tag, input bit rs, input bit v, input logic [63:0] d,
                      input bit sw, input bit lst, input bit acc);
    rst = rs; in_valid = v; in_data = d; in_switch = sw; in_last = lst;
    @(posedge clk);
    for (int r = ROWS - 1; r > 0; r--) begin
      hd[r] = hd[r-1]; hv[r] = hv[r-1]; hs[r] = hs[r-1];
    end
    hd[0] = acc ? d : '0;
    hv[0] = acc;
    hs[0] = acc & sw;
    if (rs)
      for (int r = 0; r < ROWS; r++) begin
        hd[r] = '0; hv[r] = 1'b0; hs[r] = 1'b0;
      end
    #1;
    check_rows(tag);
  endtask

  task automatic ctl(input string tag, input bit rdy, input int cnt, input bit td);
    chk({tag, ".in_ready"},  in_ready,  rdy);
    chk({tag, ".vec_count"}, vec_count, cnt);
    chk({tag, ".tile_done"}, tile_done, td);
  endtask

  initial begin
    for (int r = 0; r < ROWS; r++) begin
      hd[r] = '0; hv[r] = 1'b0; hs[r] = 1'b0;
    end

    // Reset held two cycles
    step("rst0", 1, 0, '0, 0, 0, 0);
    step("rst1", 1, 0, '0, 0, 0, 0);
    ctl("rst", 1, 0, 0);

    // Single last vector: 3 stall cycles, tile_done after edge k+3
    step("single_k",  0, 1, pack(1, 2, 3, 4), 1, 1, 1); ctl("single_k",  0, 1, 0);
    step("single_k1", 0, 0, '0, 0, 0, 0);               ctl("single_k1", 0, 1, 0);
    step("single_k2", 0, 0, '0, 0, 0, 0);               ctl("single_k2", 0, 1, 0);
    step("single_k3", 0, 0, '0, 0, 0, 0);               ctl("single_k3", 1, 0, 1);
    step("single_k4", 0, 0, '0, 0, 0, 0);               ctl("single_k4", 1, 0, 0);

    // Five back-to-back vectors, last on the fifth
    for (int i = 0; i < 5; i++) begin
      step($sformatf("stream%0d", i), 0, 1,
           pack(16'(10 + i), 16'(20 + i), 16'(30 + i), 16'(40 + i)), i[0], (i == 4), 1);
      ctl($sformatf("stream%0d", i), (i < 4), i + 1, 0);
    end
    step("stream_d1", 0, 0, '0, 0, 0, 0); ctl("stream_d1", 0, 5, 0);
    step("stream_d2", 0, 0, '0, 0, 0, 0); ctl("stream_d2", 0, 5, 0);
    step("stream_d3", 0, 0, '0, 0, 0, 0); ctl("stream_d3", 1, 0, 1);
    step("stream_d4", 0, 0, '0, 0, 0, 0); ctl("stream_d4", 1, 0, 0);

    // Bubble between 7 and 8 must be preserved on every row
    step("bub7",  0, 1, pack(7, 7, 7, 7), 0, 0, 1); ctl("bub7",  1, 1, 0);
    step("bub_0", 0, 0, pack(5, 5, 5, 5), 1, 1, 0); ctl("bub_0", 1, 1, 0);
    step("bub8",  0, 1, pack(8, 8, 8, 8), 0, 1, 1); ctl("bub8",  0, 2, 0);

    // 99 held valid during drain: refused, then taken on the first IDLE cycle
    step("hold1", 0, 1, pack(99, 99, 99, 99), 1, 0, 0); ctl("hold1", 0, 2, 0);
    step("hold2", 0, 1, pack(99, 99, 99, 99), 1, 0, 0); ctl("hold2", 0, 2, 0);
    step("hold3", 0, 1, pack(99, 99, 99, 99), 1, 0, 0); ctl("hold3", 1, 0, 1);
    step("take99", 0, 1, pack(99, 99, 99, 99), 1, 0, 1); ctl("take99", 1, 1, 0);

    // Reset while a last vector is still in flight: no tile_done afterwards
    step("pre_rst", 0, 1, pack(50, 51, 52, 53), 1, 1, 1); ctl("pre_rst", 0, 2, 0);
    step("pre_rst1", 0, 0, '0, 0, 0, 0);                  ctl("pre_rst1", 0, 2, 0);
    step("mid_rst", 1, 0, '0, 0, 0, 0);                   ctl("mid_rst", 1, 0, 0);
    step("post_rst1", 0, 0, '0, 0, 0, 0);                 ctl("post_rst1", 1, 0, 0);
    step("post_rst2", 0, 0, '0, 0, 0, 0);                 ctl("post_rst2", 1, 0, 0);
    step("restart", 0, 1, pack(1, 1, 1, 1), 0, 0, 1);     ctl("restart", 1, 1, 0);
    for (int i = 0; i < ROWS; i++) begin
      step($sformatf("flush%0d", i), 0, 0, '0, 0, 0, 0);
      ctl($sformatf("flush%0d", i), 1, 1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/systolic_input_skew.md
Name: systolic_input_skew

Overview:
- Upstream feeder for the west edge of the PE array: accepts one ROWS-wide activation vector per cycle via valid/ready handshake.
- Emits per-row input, valid and switch streams, staggered so row r lags row 0 by r cycles; this is the diagonal wavefront the systolic array needs.
- Tracks tile boundaries and holds off the producer while the last vector of a tile drains diagonally into the array.

Parameters:
- ROWS, 4, number of PE rows driven; must be >= 1.
- DATA_WIDTH, 16, activation width (signed fixed-point, passed through unmodified).
- CNT_WIDTH, 16, width of the per-tile vector counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has a vector on in_data.
- in_ready  out  1  block can accept; transfer occurs when in_valid && in_ready at a rising edge.
- in_data  in  ROWS*DATA_WIDTH  packed vector; row r at bits [r*DATA_WIDTH +: DATA_WIDTH].
- in_switch  in  1  weight-switch flag travelling with this vector.
- in_last  in  1  this vector is the final one of the tile.
- row_input_out  out  ROWS*DATA_WIDTH  per-row activation to PE column 0 (input port).
- row_valid_out  out  ROWS  per-row valid to PE column 0.
- row_switch_out  out  ROWS  per-row switch to PE column 0.
- vec_count  out  CNT_WIDTH  vectors accepted in the current tile.
- tile_done  out  1  one-cycle pulse when row ROWS-1 presents the last vector of a tile.

Behaviour:
- Reset (sync, rst=1 at edge): all row_* outputs 0, all internal delay stages 0, vec_count=0, tile_done=0, state=IDLE. Reset mid-tile discards all in-flight data; the next cycle outputs all zeros. in_ready=1 once reset deasserts.
- State IDLE: in_ready=1. An accepted vector moves to STREAM, or directly to DRAIN if in_last=1.
- State STREAM: in_ready=1. Each accepted vector increments vec_count. vec_count saturates at 2^CNT_WIDTH-1.
- State DRAIN: in_ready=0. The drain counter is loaded with ROWS-1 at the accepting edge and decrements each cycle. On reaching 0 the block returns to IDLE and clears vec_count to 0.
- ROWS=1: a last vector returns the block straight to IDLE (no DRAIN).
- Acceptance with in_last at edge k:
  - vec_count includes that vector.
  - tile_done is registered high in the cycle after edge k+ROWS-1, which is the same cycle row ROWS-1 shows that vector.
  - in_ready is 0 for exactly ROWS-1 cycles after edge k.
- Skew datapath: row r has a chain of r+1 registers carrying {data, valid, switch}.
  - Stage 0 of every row loads at each edge. On a transfer it takes {in_data row r, 1, in_switch}; otherwise a bubble {0, 0, 0}.
  - Latency for row r is r+1 edges from the accepting edge.
  - Outputs are purely registered; there is no combinational path from the in_* ports to the row_* outputs.
- Bubbles: in_valid=0 in IDLE/STREAM injects zero/invalid entries. The diagonal stays aligned and no data is compacted.
- in_ready is a function of state only, never of in_valid.
- in_switch and in_last are ignored unless a transfer occurs.
- No backpressure from the array: the datapath shifts every cycle, including during DRAIN (bubbles enter).
- Simultaneous events:
  - in_last accepted while tile_done from the previous tile is pending cannot occur, because DRAIN blocks acceptance.
  - rst has priority over everything.

Test Plan:
- ROWS=4, reset held 2 cycles -> all row_* =0, in_ready=1, vec_count=0, tile_done=0.
- Accept a single vector {r0=1,r1=2,r2=3,r3=4}, switch=1, last=1 at edge k -> row r shows value r+1 with valid and switch high only in the cycle after edge k+r; in_ready=0 for 3 cycles; tile_done pulses in the cycle after edge k+3; vec_count 1 then 0.
- Stream 5 back-to-back vectors (row0 values 10..14, last on the 5th) -> row0 shows 10..14 on consecutive cycles; row3 shows the same sequence 3 cycles later; vec_count reaches 5; tile_done fires once.
- in_valid pattern 1,0,1 with values 7, 8 -> every row shows 7, a zero/invalid bubble, then 8, preserving the gap; vec_count=2.
- in_valid held high during DRAIN with value 99 -> 99 is not accepted and never appears on any row; it is accepted on the first cycle after returning to IDLE.
- rst asserted while row2/row3 still hold in-flight data -> all row_* =0 the next cycle, state IDLE, in_ready=1; no tile_done pulse.
